// File: rtl/freq_meter_multi_pkg.sv
// Purpose : shared FSM encodings and width helper for the multi-channel frequency meter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package freq_meter_multi_pkg;

  // Two-state controller: idle, or a gate is open.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GATE = 1'b1;

  // Default count width: a channel can toggle at most at clk/2,
  // so a one-second gate never needs more bits than this.
  function automatic int cnt_w_for(input longint clk_hz);
    return $clog2(clk_hz / 2);
  endfunction

endpackage

// File: rtl/freq_meter_multi_if.sv
// Purpose : control/status bundle between the frequency meter and its user.
// Latency : n/a (wires only).
// Backpressure: none; results are level-held between done pulses.
// Signals : waveform (async inputs), enable, start, cont -> meter;
//           busy, done, frequency (ch i at [i*CNT_W +: CNT_W]), overflow <- meter.
interface freq_meter_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 26
);
  logic [NUM_CH-1:0]       waveform;
  logic                    enable;
  logic                    start;
  logic                    cont;
  logic                    busy;
  logic                    done;
  logic [NUM_CH*CNT_W-1:0] frequency;
  logic [NUM_CH-1:0]       overflow;

  modport master (
    output waveform, enable, start, cont,
    input  busy, done, frequency, overflow
  );

  modport slave (
    input  waveform, enable, start, cont,
    output busy, done, frequency, overflow
  );
endinterface

// File: rtl/freq_meter_multi_chan.sv
// Purpose : one channel: 2-flop synchroniser, rising-edge detect, saturating edge counter with sticky overflow.
// Latency : pad to counted edge 3 clk; o_count_next/o_ovf_next are combinational from the counter state.
// Backpressure: none; counter holds at all-ones once saturated.
// Ports   : clk, reset_n; i_waveform (async), i_clear (zero counter/ovf), i_count_en (accept edges);
//           o_count_next = counter + edge (saturating), o_ovf_next = ovf | saturating increment.
module freq_meter_multi_chan #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_waveform,
  input  logic             i_clear,
  input  logic             i_count_en,
  output logic [CNT_W-1:0] o_count_next,
  output logic             o_ovf_next
);
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             w_edge;
  logic             w_full;

  assign w_edge       = r_s2 & ~r_s3;
  assign w_full       = &r_cnt;
  assign o_count_next = w_full ? r_cnt : r_cnt + CNT_W'(w_edge);
  assign o_ovf_next   = r_ovf | (w_full & w_edge);

  // Synchroniser and edge flops run regardless of gate state so that
  // opening a gate never produces a spurious edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_waveform;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Clear beats count: at a gate boundary the edge of that cycle is already
  // folded into o_count_next, which the top latches as the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_count_en) begin
      r_cnt <= o_count_next;
      r_ovf <= o_ovf_next;
    end
  end
endmodule

// File: rtl/freq_meter_multi.sv
// Purpose : NUM_CH-channel gated frequency counter with one-shot, continuous, abort and saturation.
// Latency : done pulses the cycle after the last gate cycle; results held until the next done.
// Backpressure: none; start ignored while busy, abort (enable=0) drops the gate without done.
// Ports   : clk, reset_n (async, active low); bus (slave): waveform, enable, start, cont in;
//           busy, done, frequency, overflow out.
module freq_meter_multi
  import freq_meter_multi_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int GATE_CYCLES = 100_000_000,
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = cnt_w_for(CLK_FREQ_HZ)
) (
  input logic               clk,
  input logic               reset_n,
  freq_meter_multi_if.slave bus
);
  localparam int             GW   = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]  LAST = GW'(GATE_CYCLES - 1);

  logic [0:0]              r_state;
  logic [GW-1:0]           r_gate_cnt;
  logic                    r_done;
  logic [NUM_CH*CNT_W-1:0] r_frequency;
  logic [NUM_CH-1:0]       r_overflow;
  logic [NUM_CH*CNT_W-1:0] w_count_next;
  logic [NUM_CH-1:0]       w_ovf_next;
  logic                    w_in_gate;
  logic                    w_last;
  logic                    w_clear;

  assign w_in_gate = (r_state == ST_GATE);
  assign w_last    = w_in_gate && (r_gate_cnt == LAST);
  // Counters stay zeroed outside a gate, on abort, and restart from zero at
  // every gate boundary so back-to-back gates have no dead cycle.
  assign w_clear   = !w_in_gate || !bus.enable || w_last;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    freq_meter_multi_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_waveform   (bus.waveform[g]),
      .i_clear      (w_clear),
      .i_count_en   (w_in_gate),
      .o_count_next (w_count_next[g*CNT_W +: CNT_W]),
      .o_ovf_next   (w_ovf_next[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_gate_cnt  <= '0;
      r_done      <= 1'b0;
      r_frequency <= '0;
      r_overflow  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.enable && (bus.start || bus.cont)) begin
            r_state    <= ST_GATE;
            r_gate_cnt <= '0;
          end
        end
        default: begin
          if (!bus.enable) begin
            // Abort wins even on the last cycle: no done, results untouched.
            r_state    <= ST_IDLE;
            r_gate_cnt <= '0;
          end else if (w_last) begin
            r_frequency <= w_count_next;
            r_overflow  <= w_ovf_next;
            r_done      <= 1'b1;
            r_gate_cnt  <= '0;
            if (!bus.cont) begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_gate_cnt <= r_gate_cnt + GW'(1);
          end
        end
      endcase
    end
  end

  assign bus.busy      = w_in_gate;
  assign bus.done      = r_done;
  assign bus.frequency = r_frequency;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_freq_meter_multi.sv
// Purpose : self-checking bench for freq_meter_multi (wide-count and 4-bit-count instances side by side).
// Latency : checks done 1000 clk after the start-capture edge with GATE_CYCLES=1000.
// Backpressure: n/a.
module tb_freq_meter_multi;
  localparam int NCH  = 4;
  localparam int WA   = 26;
  localparam int WB   = 4;
  localparam int GATE = 1000;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic enable  = 1'b0;
  logic start   = 1'b0;
  logic cont    = 1'b0;
  logic man2    = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Free-running waveform generators, toggling on negedge (away from the sampling edge).
  // half[i] = half period in clk cycles, 0 = tied low. Channel 4 feeds instance B only.
  int half [5];
  int ph   [5];
  bit [4:0] wf;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (half[i] == 0) begin
        wf[i] <= 1'b0;
        ph[i] <= 0;
      end else if (ph[i] >= half[i] - 1) begin
        wf[i] <= ~wf[i];
        ph[i] <= 0;
      end else begin
        ph[i] <= ph[i] + 1;
      end
    end
  end

  freq_meter_multi_if #(.NUM_CH(NCH), .CNT_W(WA)) ifa ();
  freq_meter_multi_if #(.NUM_CH(NCH), .CNT_W(WB)) ifb ();

  assign ifa.waveform = {wf[3], wf[2] | man2, wf[1], wf[0]};
  assign ifa.enable   = enable;
  assign ifa.start    = start;
  assign ifa.cont     = cont;
  assign ifb.waveform = {2'b00, wf[4], wf[0]};
  assign ifb.enable   = enable;
  assign ifb.start    = start;
  assign ifb.cont     = cont;

  freq_meter_multi #(
    .CLK_FREQ_HZ (100_000_000), .GATE_CYCLES (GATE), .NUM_CH (NCH), .CNT_W (WA)
  ) u_dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifa.slave)
  );

  freq_meter_multi #(
    .CLK_FREQ_HZ (100_000_000), .GATE_CYCLES (GATE), .NUM_CH (NCH), .CNT_W (WB)
  ) u_dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifb.slave)
  );

  typedef struct {
    string name;
    int    h0, h1, h2, h3;
    int    e0, e1, e2, e3;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] fa(input int c);
    return 64'(ifa.frequency[c*WA +: WA]);
  endfunction

  function automatic logic [63:0] fb(input int c);
    return 64'(ifb.frequency[c*WB +: WB]);
  endfunction

  task automatic set_halves(input int h0, input int h1, input int h2, input int h3);
    half[0] = h0; half[1] = h1; half[2] = h2; half[3] = h3;
    repeat (100) @(negedge clk);
  endtask

  // Pulse start; lat = cycles from the start-capture edge until done is seen.
  task automatic oneshot(input bit hold, output int lat);
    @(negedge clk); start = 1'b1;
    @(negedge clk); if (!hold) start = 1'b0;
    lat = 0;
    chk("busy_open", 64'(ifa.busy), 1);
    while (ifa.done !== 1'b1 && lat < 1200) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  // Wait for the next done from a done cycle, applying up to two actions on the way.
  // kind: 1 man2=1, 2 man2=0, 3 cont=0.
  task automatic gate_wait(input int a_cyc, input int a_kind, input int b_cyc, input int b_kind,
                           output int iv);
    iv = 0;
    do begin
      @(negedge clk);
      iv++;
      for (int k = 0; k < 2; k++) begin
        int cyc  = (k == 0) ? a_cyc : b_cyc;
        int kind = (k == 0) ? a_kind : b_kind;
        if (iv == cyc) begin
          case (kind)
            1: man2 = 1'b1;
            2: man2 = 1'b0;
            3: cont = 1'b0;
            default: ;
          endcase
        end
      end
    end while (ifa.done !== 1'b1 && iv < 1200);
  endtask

  task automatic count_dones(input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (ifa.done === 1'b1 || ifb.done === 1'b1) n++;
    end
  endtask

  initial begin
    int lat;
    int iv;
    int nd;
    int sum0;

    tbl[0] = '{name: "spec",  h0: 10, h1: 20, h2: 0,  h3: 2,  e0: 50,  e1: 25,  e2: 0,  e3: 250};
    tbl[1] = '{name: "mixA",  h0: 5,  h1: 50, h2: 25, h3: 4,  e0: 100, e1: 10,  e2: 20, e3: 125};
    tbl[2] = '{name: "quiet", h0: 0,  h1: 0,  h2: 0,  h3: 0,  e0: 0,   e1: 0,   e2: 0,  e3: 0};
    tbl[3] = '{name: "fast",  h0: 2,  h1: 2,  h2: 10, h3: 20, e0: 250, e1: 250, e2: 50, e3: 25};
    half[4] = 50;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(ifa.busy), 0);
    chk("rst_done", 64'(ifa.done), 0);
    chk("rst_freq", 64'(|ifa.frequency), 0);
    chk("rst_ovf", 64'(ifa.overflow), 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", 64'(ifa.busy), 0);

    // Table-driven one-shot measurements
    for (int v = 0; v < 4; v++) begin
      int ex [4];
      ex[0] = tbl[v].e0; ex[1] = tbl[v].e1; ex[2] = tbl[v].e2; ex[3] = tbl[v].e3;
      set_halves(tbl[v].h0, tbl[v].h1, tbl[v].h2, tbl[v].h3);
      oneshot(1'b0, lat);
      chk({tbl[v].name, "_lat"}, 64'(lat), GATE);
      chk({tbl[v].name, "_b_done"}, 64'(ifb.done), 1);
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("%s_a_ch%0d", tbl[v].name, c), fa(c), 64'(ex[c]));
      end
      chk({tbl[v].name, "_a_ovf"}, 64'(ifa.overflow), 0);
      chk({tbl[v].name, "_b_ch0"}, fb(0), 64'((ex[0] > 15) ? 15 : ex[0]));
      chk({tbl[v].name, "_b_ch1"}, fb(1), 10);
      chk({tbl[v].name, "_b_ch23"}, fb(2) | fb(3), 0);
      chk({tbl[v].name, "_b_ovf"}, 64'(ifb.overflow), 64'((ex[0] > 15) ? 1 : 0));
      @(negedge clk);
      chk({tbl[v].name, "_done_pulse"}, 64'(ifa.done), 0);
      chk({tbl[v].name, "_busy_after"}, 64'(ifa.busy), 0);
      chk({tbl[v].name, "_b_busy_after"}, 64'(ifb.busy), 0);
    end

    // Continuous mode, edges placed on and just after the last gate cycle of ch2
    set_halves(10, 20, 0, 2);
    man2 = 1'b0;
    @(negedge clk); cont = 1'b1;
    iv = 0;
    while (ifa.done !== 1'b1 && iv < 1200) begin
      @(negedge clk);
      iv++;
    end
    chk("cont_first_done", 64'(ifa.done), 1);
    sum0 = 0;
    gate_wait(997, 1, 0, 0, iv);
    chk("cont_g1_interval", 64'(iv), GATE);
    chk("cont_g1_ch2_last_cycle_edge", fa(2), 1);
    chk("cont_g1_ch3", fa(3), 250);
    sum0 += int'(fa(0));
    gate_wait(500, 2, 998, 1, iv);
    chk("cont_g2_interval", 64'(iv), GATE);
    chk("cont_g2_ch2_late_edge", fa(2), 0);
    sum0 += int'(fa(0));
    gate_wait(500, 2, 0, 0, iv);
    chk("cont_g3_interval", 64'(iv), GATE);
    chk("cont_g3_ch2_carried_edge", fa(2), 1);
    sum0 += int'(fa(0));
    chk("cont_ch0_sum3", 64'(sum0), 150);
    gate_wait(500, 3, 0, 0, iv);
    chk("cont_drop_interval", 64'(iv), GATE);
    chk("cont_drop_ch0", fa(0), 50);
    @(negedge clk);
    chk("cont_drop_busy", 64'(ifa.busy), 0);
    count_dones(1100, nd);
    chk("cont_drop_no_more_done", 64'(nd), 0);

    // Abort mid-gate
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (499) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(ifa.busy), 0);
    count_dones(1100, nd);
    chk("abort_no_done", 64'(nd), 0);
    chk("abort_hold_ch0", fa(0), 50);
    chk("abort_hold_ch3", fa(3), 250);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("start_while_disabled", 64'(ifa.busy), 0);
    enable = 1'b1;
    set_halves(5, 50, 25, 4);
    oneshot(1'b0, lat);
    chk("fresh_lat", 64'(lat), GATE);
    chk("fresh_ch0", fa(0), 100);
    chk("fresh_ch1", fa(1), 10);
    chk("fresh_ch2", fa(2), 20);
    chk("fresh_ch3", fa(3), 125);

    // Start held high through the whole gate: no restart
    oneshot(1'b1, lat);
    chk("hold_lat", 64'(lat), GATE);
    chk("hold_ch0", fa(0), 100);
    chk("hold_ch3", fa(3), 125);
    @(negedge clk);
    chk("hold_busy_after", 64'(ifa.busy), 0);

    // Asynchronous reset in the middle of a gate
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (300) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(ifa.busy), 0);
    chk("mid_rst_done", 64'(ifa.done), 0);
    chk("mid_rst_freq_a", 64'(|ifa.frequency), 0);
    chk("mid_rst_freq_b", 64'(|ifb.frequency), 0);
    chk("mid_rst_ovf_b", 64'(ifb.overflow), 0);
    @(negedge clk); reset_n = 1'b1;
    count_dones(1100, nd);
    chk("post_mid_rst_no_done", 64'(nd), 0);
    chk("post_mid_rst_freq", 64'(|ifa.frequency), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
